multi_port_insertion: RTL and testbench
=======================================

# multi_port_insertion

Parametrised successor to the single-stream insertion stage. It sits between the transaction sources and the conflict/scheduling stages. It arbitrates NUM_PORTS AXI-Stream sources round-robin and admits a transaction only if it does not conflict (RAW/WAW/WAR) with the open batch. Admitted transactions go into a first-word-fall-through queue. Conflicting transactions close the batch, and the block publishes batch dependency unions for the global manager.

## Interface
Parameters:
- ID_WIDTH, 64, owner/program ID width
- DEP_WIDTH, 256, dependency bit-vector width
- NUM_PORTS, 2, input stream count (1..8)
- QUEUE_DEPTH, 32, queue entries; power of two, ≥2
- MAX_BATCH_SIZE, 16, transactions admitted per batch before auto-close (≥1)

Ports:
- clk  in  1  clock; one clock domain; all logic rises on posedge
- rst  in  1  synchronous, active-high reset
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tready  out  NUM_PORTS  per-port ready (combinational)
- s_axis_tdata_owner_programID  in  NUM_PORTS*ID_WIDTH  port p at [p*ID_WIDTH +: ID_WIDTH]
- s_axis_tdata_read_dependencies  in  NUM_PORTS*DEP_WIDTH  same packing
- s_axis_tdata_write_dependencies  in  NUM_PORTS*DEP_WIDTH  same packing
- m_axis_tvalid  out  1  queue not empty
- m_axis_tready  in  1  downstream accept
- m_axis_tdata_owner_programID  out  ID_WIDTH  queue head ID
- m_axis_tdata_read_dependencies  out  DEP_WIDTH  queue head read set
- m_axis_tdata_write_dependencies  out  DEP_WIDTH  queue head write set
- batch_completed  in  1  single-cycle pulse; closes and clears the current batch
- batch_read_deps_union  out  DEP_WIDTH  OR of admitted read sets this batch
- batch_write_deps_union  out  DEP_WIDTH  OR of admitted write sets this batch
- batch_owner_id  out  ID_WIDTH  ID of first admitted transaction of the batch
- batch_count  out  $clog2(MAX_BATCH_SIZE+1)  transactions admitted this batch
- batch_closed  out  1  batch accepts no more transactions
- raw_conflicts, waw_conflicts, war_conflicts  out  32 each  conflict event counters
- transactions_processed  out  32  admitted transaction count
- queue_occupancy  out  $clog2(QUEUE_DEPTH)+1  current entries

## Operation
- Candidate each cycle: first port with tvalid at or after rr_ptr, searching cyclically. No candidate means no grant.
- Conflict test against registered unions:
  - RAW = |(cand.read & write_union)
  - WAW = |(cand.write & write_union)
  - WAR = |(cand.write & read_union)
- Admit condition: !rst & !batch_completed & !batch_closed & !full & !conflict. On admit:
  - s_axis_tready[cand]=1; all other readies are 0.
  - Push to queue; OR sets into unions; batch_count++; transactions_processed++.
  - If batch_count was 0, latch batch_owner_id.
  - rr_ptr ← cand+1 (mod NUM_PORTS).
- Conflict on candidate (with !batch_closed, !batch_completed):
  - Not accepted; batch_closed←1.
  - Each of RAW/WAW/WAR counters increments by 1 if its condition holds. Several may increment together.
  - Counting happens once per port stall: a per-port counted flag is set here and cleared when that port is admitted or on batch_completed.
  - rr_ptr ← cand+1.
- Auto-close: batch_closed←1 at the edge where batch_count reaches MAX_BATCH_SIZE.
- batch_completed:
  - Clears unions, batch_count, batch_closed, counted flags and batch_owner_id (to 0).
  - Nothing is admitted that cycle.
  - Queue contents and rr_ptr are untouched.
- Queue: circular buffer with $clog2(QUEUE_DEPTH)-bit head/tail pointers that wrap naturally, plus an explicit occupancy count.
  - full = (occupancy==QUEUE_DEPTH); empty = (occupancy==0).
  - Pop on m_axis_tvalid & m_axis_tready.
  - Simultaneous push and pop leaves occupancy unchanged. Push at full is impossible because tready is gated.
- Counters are 32-bit and wrap silently.

## Timing
- Reset (rst high at an edge): all outputs and state are 0. This includes queue pointers, occupancy, unions, counters and rr_ptr. s_axis_tready=0 while rst is high.
- Admit-to-m_axis_tvalid latency is 1 cycle. Head data is valid in the cycle tvalid rises and holds stable until popped.
- Unions, batch_count and batch_closed update at the admit edge, so the next cycle's candidate is tested against them. Back-to-back admits at 1 per cycle are supported.
- Sustained throughput is 1 in, 1 out per cycle when conflict-free and downstream is ready.
- rst mid-batch discards queue contents; no partial-state retention.

## Test plan
- Reset: hold rst 2 cycles with tvalid on all ports -> all readies 0, m_axis_tvalid 0, all counters/unions 0.
- Round-robin: ports 0 and 1 valid, disjoint sets (read bits 1 and 2), m_axis_tready=1 -> grants 0,1,0,1; transactions_processed increments each cycle; output order matches grant order one cycle later.
- RAW close: admit write={bit5}, then candidate read={bit5} -> candidate rejected, raw_conflicts=1, batch_closed=1, no readies. Candidate stays valid 10 cycles -> raw_conflicts still 1. Pulse batch_completed -> candidate admitted next cycle, batch_owner_id=its ID.
- Multi-type: union read={3}, write={3}; candidate write={3} -> waw_conflicts and war_conflicts both +1, raw unchanged.
- Full/wrap: QUEUE_DEPTH=4, MAX_BATCH_SIZE=16, m_axis_tready=0, 6 disjoint transactions -> 4 admitted, occupancy=4, readies 0. Then tready=1 with pushes continuing for 3×DEPTH -> FIFO order preserved across pointer wrap; occupancy never exceeds 4.
- Batch size limit: MAX_BATCH_SIZE=3, 5 disjoint transactions -> 3 admitted, batch_closed=1, batch_count=3, no conflict counts. batch_completed in the same cycle as a valid candidate -> no admit that cycle, admit the next.

Source files
------------

// File: rtl/multi_port_insertion.sv
// multi_port_insertion
//   Arbitrates NUM_PORTS stream sources round-robin and admits a transaction
//   into a first-word-fall-through queue only when its read/write dependency
//   sets do not collide (RAW/WAW/WAR) with the currently open batch. A
//   collision closes the batch; the batch is also closed once MAX_BATCH_SIZE
//   transactions have been admitted. batch_completed reopens an empty batch.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   s_axis_*                      NUM_PORTS packed input streams (port p at p*W +: W)
//   m_axis_*                      queue head output stream
//   batch_completed               pulse: clear unions/count/closed/owner
//   batch_*_deps_union            OR of admitted read/write sets this batch
//   batch_owner_id, batch_count   first admitted ID, admitted count this batch
//   batch_closed                  batch takes no more transactions
//   raw/waw/war_conflicts         conflict event counters (wrap at 2^32)
//   transactions_processed        admitted transaction counter (wraps)
//   queue_occupancy               entries currently held in the queue
module multi_port_insertion #(
  parameter int ID_WIDTH       = 64,
  parameter int DEP_WIDTH      = 256,
  parameter int NUM_PORTS      = 2,
  parameter int QUEUE_DEPTH    = 32,
  parameter int MAX_BATCH_SIZE = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                s_axis_tready,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]       s_axis_tdata_owner_programID,
  input  logic [NUM_PORTS*DEP_WIDTH-1:0]      s_axis_tdata_read_dependencies,
  input  logic [NUM_PORTS*DEP_WIDTH-1:0]      s_axis_tdata_write_dependencies,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [ID_WIDTH-1:0]                 m_axis_tdata_owner_programID,
  output logic [DEP_WIDTH-1:0]                m_axis_tdata_read_dependencies,
  output logic [DEP_WIDTH-1:0]                m_axis_tdata_write_dependencies,
  input  logic                                batch_completed,
  output logic [DEP_WIDTH-1:0]                batch_read_deps_union,
  output logic [DEP_WIDTH-1:0]                batch_write_deps_union,
  output logic [ID_WIDTH-1:0]                 batch_owner_id,
  output logic [$clog2(MAX_BATCH_SIZE+1)-1:0] batch_count,
  output logic                                batch_closed,
  output logic [31:0]                         raw_conflicts,
  output logic [31:0]                         waw_conflicts,
  output logic [31:0]                         war_conflicts,
  output logic [31:0]                         transactions_processed,
  output logic [$clog2(QUEUE_DEPTH):0]        queue_occupancy
);

  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = $clog2(MAX_BATCH_SIZE + 1);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PORT_W-1:0] LAST_PORT  = PORT_W'(NUM_PORTS - 1);
  localparam logic [PTR_W:0]    DEPTH_OCC  = (PTR_W + 1)'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0]  LAST_SLOT  = CNT_W'(MAX_BATCH_SIZE - 1);

  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    return (p == LAST_PORT) ? '0 : p + 1'b1;
  endfunction

  logic [ID_WIDTH-1:0]  in_id [NUM_PORTS];
  logic [DEP_WIDTH-1:0] in_rd [NUM_PORTS];
  logic [DEP_WIDTH-1:0] in_wr [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign in_id[g] = s_axis_tdata_owner_programID[g*ID_WIDTH +: ID_WIDTH];
    assign in_rd[g] = s_axis_tdata_read_dependencies[g*DEP_WIDTH +: DEP_WIDTH];
    assign in_wr[g] = s_axis_tdata_write_dependencies[g*DEP_WIDTH +: DEP_WIDTH];
  end

  logic [PORT_W-1:0]    rr_ptr;
  logic [NUM_PORTS-1:0] counted;
  logic [PTR_W-1:0]     head, tail;

  logic [ID_WIDTH-1:0]  mem_id [QUEUE_DEPTH];
  logic [DEP_WIDTH-1:0] mem_rd [QUEUE_DEPTH];
  logic [DEP_WIDTH-1:0] mem_wr [QUEUE_DEPTH];

  // ---- stage p0: candidate selection, conflict test, admit decision ----
  logic [PORT_W-1:0]    scan_idx_p0, cand_idx_p0;
  logic                 cand_vld_p0;
  logic [ID_WIDTH-1:0]  cand_id_p0;
  logic [DEP_WIDTH-1:0] cand_rd_p0, cand_wr_p0;
  logic                 raw_hit_p0, waw_hit_p0, war_hit_p0, conflict_p0;
  logic                 batch_open_p0, conflict_evt_p0, vld_p0;
  logic                 q_full, pop;

  // Walk the ports cyclically starting at rr_ptr; first valid port wins.
  always_comb begin
    cand_vld_p0 = 1'b0;
    cand_idx_p0 = '0;
    scan_idx_p0 = rr_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!cand_vld_p0 && s_axis_tvalid[scan_idx_p0]) begin
        cand_vld_p0 = 1'b1;
        cand_idx_p0 = scan_idx_p0;
      end
      scan_idx_p0 = next_port(scan_idx_p0);
    end
  end

  assign cand_id_p0 = in_id[cand_idx_p0];
  assign cand_rd_p0 = in_rd[cand_idx_p0];
  assign cand_wr_p0 = in_wr[cand_idx_p0];

  assign raw_hit_p0  = |(cand_rd_p0 & batch_write_deps_union);
  assign waw_hit_p0  = |(cand_wr_p0 & batch_write_deps_union);
  assign war_hit_p0  = |(cand_wr_p0 & batch_read_deps_union);
  assign conflict_p0 = raw_hit_p0 | waw_hit_p0 | war_hit_p0;

  assign q_full          = (queue_occupancy == DEPTH_OCC);
  assign batch_open_p0   = !rst && !batch_completed && !batch_closed;
  // A conflict closes the batch even when the queue is full.
  assign conflict_evt_p0 = batch_open_p0 && cand_vld_p0 && conflict_p0;
  assign vld_p0          = batch_open_p0 && cand_vld_p0 && !conflict_p0 && !q_full;

  always_comb begin
    s_axis_tready = '0;
    if (vld_p0) s_axis_tready[cand_idx_p0] = 1'b1;
  end

  assign m_axis_tvalid = (queue_occupancy != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;

  // Head data is forced to zero while empty so the idle output is clean.
  assign m_axis_tdata_owner_programID    = m_axis_tvalid ? mem_id[head] : '0;
  assign m_axis_tdata_read_dependencies  = m_axis_tvalid ? mem_rd[head] : '0;
  assign m_axis_tdata_write_dependencies = m_axis_tvalid ? mem_wr[head] : '0;

  // ---- stage p1: queue storage, batch state and counters ----
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      mem_id[tail] <= cand_id_p0;
      mem_rd[tail] <= cand_rd_p0;
      mem_wr[tail] <= cand_wr_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr                 <= '0;
      head                   <= '0;
      tail                   <= '0;
      queue_occupancy        <= '0;
      batch_read_deps_union  <= '0;
      batch_write_deps_union <= '0;
      batch_owner_id         <= '0;
      batch_count            <= '0;
      batch_closed           <= 1'b0;
      counted                <= '0;
      raw_conflicts          <= '0;
      waw_conflicts          <= '0;
      war_conflicts          <= '0;
      transactions_processed <= '0;
    end else begin
      if (vld_p0) tail <= tail + 1'b1;
      if (pop)    head <= head + 1'b1;
      case ({vld_p0, pop})
        2'b10:   queue_occupancy <= queue_occupancy + 1'b1;
        2'b01:   queue_occupancy <= queue_occupancy - 1'b1;
        default: queue_occupancy <= queue_occupancy;
      endcase

      if (batch_completed) begin
        batch_read_deps_union  <= '0;
        batch_write_deps_union <= '0;
        batch_owner_id         <= '0;
        batch_count            <= '0;
        batch_closed           <= 1'b0;
        counted                <= '0;
      end else if (vld_p0) begin
        batch_read_deps_union  <= batch_read_deps_union | cand_rd_p0;
        batch_write_deps_union <= batch_write_deps_union | cand_wr_p0;
        batch_count            <= batch_count + 1'b1;
        transactions_processed <= transactions_processed + 32'd1;
        if (batch_count == '0) batch_owner_id <= cand_id_p0;
        if (batch_count == LAST_SLOT) batch_closed <= 1'b1;
        counted[cand_idx_p0]   <= 1'b0;
        rr_ptr                 <= next_port(cand_idx_p0);
      end else if (conflict_evt_p0) begin
        batch_closed <= 1'b1;
        rr_ptr       <= next_port(cand_idx_p0);
        // A stalled port is counted once until it is admitted or the batch clears.
        if (!counted[cand_idx_p0]) begin
          raw_conflicts <= raw_conflicts + 32'(raw_hit_p0);
          waw_conflicts <= waw_conflicts + 32'(waw_hit_p0);
          war_conflicts <= war_conflicts + 32'(war_hit_p0);
        end
        counted[cand_idx_p0] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_port_insertion.sv
// Bench for multi_port_insertion: instance A (3 ports, depth 4, batch 16) is
// checked every cycle against a transaction-level model; instance B (2 ports,
// batch 3) covers the batch size limit with directed constants.
module tb_multi_port_insertion;

  localparam int NP  = 3;
  localparam int IW  = 8;
  localparam int DW  = 16;
  localparam int QD  = 4;
  localparam int MB  = 16;
  localparam int NPB = 2;
  localparam int QDB = 8;
  localparam int MBB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // instance A signals
  logic [NP-1:0]            a_valid, a_ready;
  logic [IW-1:0]            in_id [NP];
  logic [DW-1:0]            in_rd [NP];
  logic [DW-1:0]            in_wr [NP];
  logic [NP*IW-1:0]         a_id;
  logic [NP*DW-1:0]         a_rd, a_wr;
  logic                     a_mvalid, a_mready, a_bc, a_bclosed;
  logic [IW-1:0]            a_mid, a_owner;
  logic [DW-1:0]            a_mrd, a_mwr, a_rdu, a_wru;
  logic [$clog2(MB+1)-1:0]  a_bcount;
  logic [31:0]              a_raw, a_waw, a_war, a_proc;
  logic [$clog2(QD):0]      a_occ;

  assign a_id = {in_id[2], in_id[1], in_id[0]};
  assign a_rd = {in_rd[2], in_rd[1], in_rd[0]};
  assign a_wr = {in_wr[2], in_wr[1], in_wr[0]};

  // instance B signals
  logic [NPB-1:0]           b_valid, b_ready;
  logic [NPB*IW-1:0]        b_id;
  logic [NPB*DW-1:0]        b_rd, b_wr;
  logic                     b_mvalid, b_mready, b_bc, b_bclosed;
  logic [IW-1:0]            b_mid, b_owner;
  logic [DW-1:0]            b_mrd, b_mwr, b_rdu, b_wru;
  logic [$clog2(MBB+1)-1:0] b_bcount;
  logic [31:0]              b_raw, b_waw, b_war, b_proc;
  logic [$clog2(QDB):0]     b_occ;

  multi_port_insertion #(.ID_WIDTH(IW), .DEP_WIDTH(DW), .NUM_PORTS(NP),
                         .QUEUE_DEPTH(QD), .MAX_BATCH_SIZE(MB)) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(a_valid), .s_axis_tready(a_ready),
    .s_axis_tdata_owner_programID(a_id),
    .s_axis_tdata_read_dependencies(a_rd),
    .s_axis_tdata_write_dependencies(a_wr),
    .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready),
    .m_axis_tdata_owner_programID(a_mid),
    .m_axis_tdata_read_dependencies(a_mrd),
    .m_axis_tdata_write_dependencies(a_mwr),
    .batch_completed(a_bc),
    .batch_read_deps_union(a_rdu), .batch_write_deps_union(a_wru),
    .batch_owner_id(a_owner), .batch_count(a_bcount), .batch_closed(a_bclosed),
    .raw_conflicts(a_raw), .waw_conflicts(a_waw), .war_conflicts(a_war),
    .transactions_processed(a_proc), .queue_occupancy(a_occ)
  );

  multi_port_insertion #(.ID_WIDTH(IW), .DEP_WIDTH(DW), .NUM_PORTS(NPB),
                         .QUEUE_DEPTH(QDB), .MAX_BATCH_SIZE(MBB)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(b_valid), .s_axis_tready(b_ready),
    .s_axis_tdata_owner_programID(b_id),
    .s_axis_tdata_read_dependencies(b_rd),
    .s_axis_tdata_write_dependencies(b_wr),
    .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
    .m_axis_tdata_owner_programID(b_mid),
    .m_axis_tdata_read_dependencies(b_mrd),
    .m_axis_tdata_write_dependencies(b_mwr),
    .batch_completed(b_bc),
    .batch_read_deps_union(b_rdu), .batch_write_deps_union(b_wru),
    .batch_owner_id(b_owner), .batch_count(b_bcount), .batch_closed(b_bclosed),
    .raw_conflicts(b_raw), .waw_conflicts(b_waw), .war_conflicts(b_war),
    .transactions_processed(b_proc), .queue_occupancy(b_occ)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- reference model of instance A (transaction level) ----
  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] rd;
    logic [DW-1:0] wr;
  } txn_t;

  txn_t          mq[$];
  int            m_rr;
  logic [DW-1:0] m_rdu, m_wru;
  logic [IW-1:0] m_owner;
  int            m_bcount;
  bit            m_bclosed;
  logic [31:0]   m_raw, m_waw, m_war, m_proc;
  bit [NP-1:0]   m_counted;
  logic [NP-1:0] last_rdy;

  task automatic model_reset();
    mq.delete();
    m_rr = 0; m_rdu = '0; m_wru = '0; m_owner = '0; m_bcount = 0; m_bclosed = 0;
    m_raw = '0; m_waw = '0; m_war = '0; m_proc = '0; m_counted = '0;
  endtask

  task automatic check_state_a();
    chk("occupancy", 64'(a_occ), 64'(mq.size()));
    chk("m_tvalid", 64'(a_mvalid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("m_id", 64'(a_mid), 64'(mq[0].id));
      chk("m_rd", 64'(a_mrd), 64'(mq[0].rd));
      chk("m_wr", 64'(a_mwr), 64'(mq[0].wr));
    end
    chk("rd_union", 64'(a_rdu), 64'(m_rdu));
    chk("wr_union", 64'(a_wru), 64'(m_wru));
    chk("owner", 64'(a_owner), 64'(m_owner));
    chk("batch_count", 64'(a_bcount), 64'(m_bcount));
    chk("batch_closed", 64'(a_bclosed), 64'(m_bclosed));
    chk("raw", 64'(a_raw), 64'(m_raw));
    chk("waw", 64'(a_waw), 64'(m_waw));
    chk("war", 64'(a_war), 64'(m_war));
    chk("processed", 64'(a_proc), 64'(m_proc));
  endtask

  task automatic step_a();
    logic [NP-1:0] exp_rdy;
    bit found, push, pop, raw, waw, war;
    int c;
    txn_t t;
    exp_rdy = '0; push = 0; found = 0; c = 0; t = '0;
    last_rdy = a_ready;
    if (rst) begin
      chk("s_tready_rst", 64'(a_ready), 64'(0));
      model_reset();
    end else begin
      pop = (mq.size() != 0) && a_mready;
      for (int k = 0; k < NP; k++) begin
        if (!found && a_valid[(m_rr + k) % NP]) begin
          found = 1;
          c = (m_rr + k) % NP;
        end
      end
      if (a_bc) begin
        m_rdu = '0; m_wru = '0; m_owner = '0; m_bcount = 0; m_bclosed = 0; m_counted = '0;
      end else if (found && !m_bclosed) begin
        raw = (in_rd[c] & m_wru) != '0;
        waw = (in_wr[c] & m_wru) != '0;
        war = (in_wr[c] & m_rdu) != '0;
        if (raw || waw || war) begin
          if (!m_counted[c]) begin
            m_raw += 32'(raw);
            m_waw += 32'(waw);
            m_war += 32'(war);
          end
          m_counted[c] = 1;
          m_bclosed = 1;
          m_rr = (c + 1) % NP;
        end else if (mq.size() < QD) begin
          push = 1;
          exp_rdy[c] = 1'b1;
          t.id = in_id[c]; t.rd = in_rd[c]; t.wr = in_wr[c];
          if (m_bcount == 0) m_owner = in_id[c];
          m_rdu |= in_rd[c];
          m_wru |= in_wr[c];
          m_bcount++;
          m_proc += 32'd1;
          m_counted[c] = 0;
          m_rr = (c + 1) % NP;
          if (m_bcount == MB) m_bclosed = 1;
        end
      end
      chk("s_tready", 64'(a_ready), 64'(exp_rdy));
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(t);
    end
  endtask

  // Inputs are applied just after a falling edge; checks run 1 time unit later.
  task automatic cycle_a(input bit do_state);
    #1;
    if (do_state) check_state_a();
    step_a();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_a();
    a_valid = '0; a_bc = 1'b0;
    for (int p = 0; p < NP; p++) begin
      in_id[p] = '0; in_rd[p] = '0; in_wr[p] = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clr_a();
    a_mready = 1'b1;
    b_valid = '0; b_id = '0; b_rd = '0; b_wr = '0; b_mready = 1'b0; b_bc = 1'b0;

    // reset with every port requesting
    a_valid = '1;
    for (int p = 0; p < NP; p++) in_id[p] = 8'(8'hA0 + p);
    cycle_a(0);
    cycle_a(1);
    chk("rst_ready", 64'(a_ready), 64'(0));
    chk("rst_mvalid", 64'(a_mvalid), 64'(0));
    chk("rst_mid", 64'(a_mid), 64'(0));
    chk("rst_proc", 64'(a_proc), 64'(0));
    chk("rst_wr_union", 64'(a_wru), 64'(0));
    rst = 1'b0;
    clr_a();

    // round-robin between ports 0 and 1
    a_valid = 3'b011;
    in_rd[0] = 16'h0002;
    in_rd[1] = 16'h0004;
    for (int k = 0; k < 4; k++) begin
      in_id[0] = 8'(8'h10 + 2 * k);
      in_id[1] = 8'(8'h11 + 2 * k);
      cycle_a(1);
      chk("rr_grant", 64'(last_rdy), 64'((k % 2 == 0) ? 1 : 2));
      chk("rr_processed", 64'(a_proc), 64'(k + 1));
    end
    clr_a();
    a_bc = 1'b1;
    cycle_a(1);
    a_bc = 1'b0;

    // RAW conflict closes the batch and is counted once
    a_valid = 3'b001;
    in_id[0] = 8'h30;
    in_wr[0] = 16'h0020;
    cycle_a(1);
    chk("raw_first_admit", 64'(last_rdy), 64'(1));
    in_id[0] = 8'h33;
    in_wr[0] = '0;
    in_rd[0] = 16'h0020;
    for (int k = 0; k < 11; k++) begin
      cycle_a(1);
      chk("raw_stall_ready", 64'(last_rdy), 64'(0));
    end
    chk("raw_count_once", 64'(a_raw), 64'(1));
    chk("raw_closed", 64'(a_bclosed), 64'(1));
    a_bc = 1'b1;
    cycle_a(1);
    chk("bc_no_admit", 64'(last_rdy), 64'(0));
    a_bc = 1'b0;
    cycle_a(1);
    chk("bc_then_admit", 64'(last_rdy), 64'(1));
    chk("bc_owner", 64'(a_owner), 64'(8'h33));
    clr_a();
    a_bc = 1'b1;
    cycle_a(1);
    a_bc = 1'b0;

    // WAW and WAR together
    a_valid = 3'b001;
    in_id[0] = 8'h40; in_rd[0] = 16'h0008; in_wr[0] = 16'h0008;
    cycle_a(1);
    a_valid = 3'b010;
    in_id[1] = 8'h41; in_rd[1] = '0; in_wr[1] = 16'h0008;
    cycle_a(1);
    chk("multi_waw", 64'(a_waw), 64'(1));
    chk("multi_war", 64'(a_war), 64'(1));
    chk("multi_raw", 64'(a_raw), 64'(1));
    clr_a();
    a_bc = 1'b1;
    cycle_a(1);
    a_bc = 1'b0;
    cycle_a(1);

    // fill to depth with downstream stalled, then stream through pointer wrap
    a_mready = 1'b0;
    a_valid = 3'b001;
    for (int k = 0; k < 6; k++) begin
      in_id[0] = 8'(8'h50 + k);
      in_rd[0] = 16'(1) << k;
      cycle_a(1);
      if (k >= 4) chk("full_ready", 64'(last_rdy), 64'(0));
    end
    chk("full_occ", 64'(a_occ), 64'(4));
    a_mready = 1'b1;
    for (int k = 0; k < 3 * QD; k++) begin
      in_id[0] = 8'(8'h60 + k);
      in_rd[0] = 16'(1) << (k % 16);
      cycle_a(1);
      chk("occ_le_depth", 64'(a_occ <= 4), 64'(1));
    end
    clr_a();
    for (int k = 0; k < 5; k++) cycle_a(1);
    a_bc = 1'b1;
    cycle_a(1);
    a_bc = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      a_valid = NP'($urandom_range(0, 7));
      for (int p = 0; p < NP; p++) begin
        in_id[p] = 8'($urandom);
        in_rd[p] = ($urandom_range(0, 1) == 1) ? (16'(1) << $urandom_range(0, 15)) : '0;
        in_wr[p] = ($urandom_range(0, 4) == 0) ? (16'(1) << $urandom_range(0, 15)) : '0;
      end
      a_mready = ($urandom_range(0, 3) != 0);
      a_bc = ($urandom_range(0, 9) == 0);
      cycle_a(1);
    end
    rst = 1'b0;

    // instance B: batch size limit of 3
    clr_a();
    a_mready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    b_mready = 1'b1;
    b_valid = 2'b01;
    b_wr = '0;
    for (int k = 0; k < 5; k++) begin
      b_id = {8'h00, 8'(8'h70 + k)};
      b_rd = {16'h0000, 16'(1) << k};
      #1;
      chk("b_grant", 64'(b_ready), 64'((k < 3) ? 1 : 0));
      @(posedge clk);
      @(negedge clk);
    end
    chk("b_count", 64'(b_bcount), 64'(3));
    chk("b_closed", 64'(b_bclosed), 64'(1));
    chk("b_raw", 64'(b_raw), 64'(0));
    chk("b_waw", 64'(b_waw), 64'(0));
    chk("b_war", 64'(b_war), 64'(0));
    chk("b_proc", 64'(b_proc), 64'(3));
    chk("b_owner", 64'(b_owner), 64'(8'h70));
    b_bc = 1'b1;
    b_id = {8'h00, 8'h7A};
    #1;
    chk("b_bc_ready", 64'(b_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    b_bc = 1'b0;
    chk("b_bc_count", 64'(b_bcount), 64'(0));
    chk("b_bc_closed", 64'(b_bclosed), 64'(0));
    chk("b_bc_owner", 64'(b_owner), 64'(0));
    #1;
    chk("b_after_bc_ready", 64'(b_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    chk("b_after_count", 64'(b_bcount), 64'(1));
    chk("b_after_owner", 64'(b_owner), 64'(8'h7A));
    chk("b_after_proc", 64'(b_proc), 64'(4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
